// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLDOFF = 2'd2
  } arb_state_e;

  // One-hot decode; callers slice the low n bits (n <= 16).
  function automatic logic [15:0] onehot(input int unsigned idx, input int unsigned n);
    logic [15:0] r;
    r = '0;
    if (idx < n) r = 16'(1) << idx;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first asserted req at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  int unsigned k;

  // Scan from the farthest candidate back towards ptr so the closest hit wins last.
  always_comb begin
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      k = (int'(ptr) + (N - 1 - i)) % N;
      if (req[k]) begin
        idx = IW'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with per-ownership burst cap and a turnaround dead time.
module rr_burst_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int MAX_BURST  = 8,
  parameter int TURNAROUND = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic                 grant_vld,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 expired
);

  localparam int IW = $clog2(N);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int HW = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

  arb_state_e    state, state_n;
  logic [IW-1:0] owner, owner_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [BW-1:0] burst_cnt, burst_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic          exp_n;
  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          release_c;
  logic [15:0]   oh_n;

  rr_pick #(.N(N)) u_pick (
    .req (req),
    .ptr (ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    ptr_n     = ptr;
    burst_n   = burst_cnt;
    hold_n    = hold_cnt;
    exp_n     = 1'b0;
    release_c = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          owner_n = pick_idx;
          burst_n = BW'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        release_c = !req[owner] || (burst_cnt == BW'(MAX_BURST));
        if (release_c) begin
          ptr_n   = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
          burst_n = '0;
          exp_n   = req[owner];
          if (TURNAROUND == 0) begin
            state_n = IDLE;
          end else begin
            state_n = HOLDOFF;
            hold_n  = HW'(TURNAROUND - 1);
          end
        end else begin
          burst_n = burst_cnt + 1'b1;
        end
      end
      HOLDOFF: begin
        if (hold_cnt == '0) state_n = IDLE;
        else                hold_n  = hold_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they stay Moore-timed.
  always_comb oh_n = onehot(int'(owner_n), N);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      owner     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      grant_vld <= 1'b0;
      grant_id  <= '0;
      expired   <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      ptr       <= ptr_n;
      burst_cnt <= burst_n;
      hold_cnt  <= hold_n;
      grant     <= (state_n == GRANT) ? oh_n[N-1:0] : '0;
      grant_vld <= (state_n == GRANT);
      grant_id  <= (state_n == GRANT) ? owner_n : '0;
      expired   <= exp_n;
    end
  end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Bench for rr_burst_arbiter: per-cycle model comparison plus directed literal checks.
module tb_rr_burst_arbiter;

  localparam int N          = 4;
  localparam int MAX_BURST  = 4;
  localparam int TURNAROUND = 1;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_vld;
  logic [1:0]   grant_id;
  logic         expired;

  int checks = 0;
  int errors = 0;

  rr_burst_arbiter #(.N(N), .MAX_BURST(MAX_BURST), .TURNAROUND(TURNAROUND)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .grant     (grant),
    .grant_vld (grant_vld),
    .grant_id  (grant_id),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, how long, dead cycles left, rotation pointer.
  int   m_owner = -1;
  int   m_held  = 0;
  int   m_dead  = 0;
  int   m_ptr   = 0;
  logic m_exp   = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_found;

  always @(posedge clk) begin
    if (!rstn) begin
      m_owner = -1; m_held = 0; m_dead = 0; m_ptr = 0; m_exp = 1'b0; m_valid = 1'b1;
    end else begin
      m_exp = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner] || m_held == MAX_BURST) begin
          m_exp   = req[m_owner];
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_dead  = TURNAROUND;
        end else begin
          m_held++;
        end
      end else if (m_dead > 0) begin
        m_dead--;
      end else if (req != '0) begin
        m_found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!m_found && req[(m_ptr + i) % N]) begin
            m_owner = (m_ptr + i) % N;
            m_found = 1'b1;
          end
        end
        m_held = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_grant",     32'(grant),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("m_grant_vld", 32'(grant_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("m_grant_id",  32'(grant_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("m_expired",   32'(expired),   32'(m_exp));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [N-1:0] seq_g [$];
  logic         seq_e [$];
  logic [N-1:0] exp_g;

  initial begin
    // Reset with all requesting
    rstn = 1'b0; req = 4'b1111;
    tick(2);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_vld",   32'(grant_vld), 32'd0);
    chk("rst_id",    32'(grant_id), 32'd0);
    chk("rst_exp",   32'(expired), 32'd0);
    rstn = 1'b1;
    tick(1);
    chk("first_grant", 32'(grant), 32'h1);
    req = 4'b0000;
    tick(4);

    // Single short request
    req = 4'b0100;
    tick(1);
    chk("short_g1", 32'(grant), 32'h4);
    chk("short_id", 32'(grant_id), 32'd2);
    tick(1);
    chk("short_g2", 32'(grant), 32'h4);
    req = 4'b0000;
    tick(1);
    chk("short_off1", 32'(grant), 32'h0);
    chk("short_noexp", 32'(expired), 32'h0);
    tick(1);
    chk("short_off2", 32'(grant), 32'h0);
    tick(2);

    // Lone requester hits the burst limit
    req = 4'b0001;
    seq_g.delete(); seq_e.delete();
    for (int i = 0; i < 7; i++) begin
      tick(1);
      seq_g.push_back(grant);
      seq_e.push_back(expired);
    end
    for (int i = 0; i < 7; i++) begin
      chk("burst_g", 32'(seq_g[i]), (i == 4 || i == 5) ? 32'h0 : 32'h1);
      chk("burst_e", 32'(seq_e[i]), (i == 4) ? 32'h1 : 32'h0);
    end
    req = 4'b0000;
    tick(4);

    // Fairness from a cleared pointer
    rstn = 1'b0; req = 4'b1111;
    tick(1);
    rstn = 1'b1;
    for (int j = 0; j < 30; j++) begin
      tick(1);
      exp_g = ((j % 6) < 4) ? 4'(1 << ((j / 6) % 4)) : 4'b0000;
      chk("fair_g", 32'(grant), 32'(exp_g));
      chk("fair_e", 32'(expired), ((j % 6) == 4) ? 32'h1 : 32'h0);
    end
    req = 4'b0000;
    tick(6);

    // Pointer wrap after owner 3
    req = 4'b1000;
    tick(1);
    chk("wrap_own3", 32'(grant), 32'h8);
    req = 4'b0011;
    tick(3);
    chk("wrap_g0", 32'(grant), 32'h1);
    tick(6);
    chk("wrap_g1", 32'(grant), 32'h2);
    req = 4'b0000;
    tick(4);

    // Reset mid-grant clears the pointer
    req = 4'b0100;
    tick(1);
    chk("midrst_pre", 32'(grant), 32'h4);
    rstn = 1'b0;
    tick(1);
    chk("midrst_drop", 32'(grant), 32'h0);
    req = 4'b1111; rstn = 1'b1;
    tick(1);
    chk("midrst_ptr0", 32'(grant), 32'h1);
    chk("midrst_id",   32'(grant_id), 32'd0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one single-owner resource, such as a shared FSM datapath or bus port, between N requesters.
- Grants one requester at a time.
- Caps each ownership at MAX_BURST cycles.
- Enforces a TURNAROUND dead time between owners.
- Sits between the requesting blocks and the resource's enable/select inputs.

Parameters:
- N, 4, number of requesters (2..16).
- MAX_BURST, 8, maximum consecutive grant cycles per ownership (>=1).
- TURNAROUND, 1, dead cycles after a release before arbitration resumes (>=0).

Ports:
- clk  input  1  clock; all logic on posedge.
- rstn  input  1  synchronous, active-low reset.
- req  input  N  request vector; req[k]=1 means requester k wants the resource.
- grant  output  N  one-hot grant, or all-zero.
- grant_vld  output  1  equals |grant.
- grant_id  output  $clog2(N)  index of the current owner; 0 when grant_vld=0.
- expired  output  1  one-cycle pulse when an ownership ended because of the burst limit.

Behaviour:
- All outputs are registered (Moore).
- Reset behaviour: when rstn=0 at a posedge, the next cycle has state=IDLE, grant=0, grant_vld=0, grant_id=0, expired=0, ptr=0, burst_cnt=0, hold_cnt=0. Reset mid-grant drops the grant at that edge with no turnaround.
- Internal registers:
  - state: IDLE, GRANT or HOLDOFF.
  - owner.
  - ptr: the round-robin start index.
  - burst_cnt: width $clog2(MAX_BURST+1).
  - hold_cnt: width $clog2(TURNAROUND+1).
- IDLE (grant=0):
  - If |req is 1 at the edge: owner <= pick(req, ptr), burst_cnt <= 1, state <= GRANT.
  - Otherwise stay in IDLE.
  - Latency from a sampled request to its grant is 1 cycle.
- pick(req, ptr): the first index k in the order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 with req[k]=1. The search wraps modulo N.
- GRANT (grant=onehot(owner), grant_id=owner):
  - Release condition at the edge: req[owner]=0 OR burst_cnt==MAX_BURST.
  - On release:
    - ptr <= (owner+1) mod N.
    - burst_cnt <= 0.
    - If TURNAROUND==0, state <= IDLE; otherwise state <= HOLDOFF with hold_cnt <= TURNAROUND-1.
  - expired <= 1 for exactly the next cycle only if the burst limit was reached while req[owner] was still 1.
  - If req[owner] drops on the same edge that burst_cnt==MAX_BURST, this is a normal release and expired stays 0.
  - Without a release: burst_cnt <= burst_cnt+1 and owner is unchanged.
  - Changes on other req bits have no effect during GRANT; there is no preemption.
- HOLDOFF (grant=0):
  - If hold_cnt==0, state <= IDLE; otherwise hold_cnt decrements.
  - req is ignored in HOLDOFF.
  - Lasts exactly TURNAROUND cycles.
- Dead cycles between consecutive grants = TURNAROUND + 1 (HOLDOFF plus the IDLE arbitration cycle).
- A lone requester holding req continuously is re-granted after the dead time.
- Grant is never two-hot; grant_id always matches grant.
- Illegal or unused state encodings return to IDLE.

Decomposition:
- Package rr_arb_pkg:
  - state enum typedef (IDLE, GRANT, HOLDOFF).
  - Helper function onehot(idx, N).
- Sub-module rr_pick:
  - Purely combinational, parameter N.
  - Inputs: req, ptr. Outputs: idx, any.
  - Instantiated once by rr_burst_arbiter.

Test Plan (N=4, MAX_BURST=4, TURNAROUND=1):
1. Reset: rstn=0 for 2 edges with req=1111 -> grant=0000, grant_vld=0, grant_id=0, expired=0. Then rstn=1 -> grant=0001 one cycle after the first sampled edge.
2. Single short request: req=0100 for 2 cycles, then 0000 -> grant=0100 for 2 cycles (plus the cycle in which the drop is sampled), grant_id=2. Then grant=0000 for at least 2 cycles, expired never 1.
3. Burst limit, lone requester: req=0001 held -> grant=0001 for exactly 4 cycles, expired=1 for one cycle, 2 dead cycles, then grant=0001 again.
4. Fairness: req=1111 constant -> grant sequence 0001, 0010, 0100, 1000, 0001. Each lasts 4 cycles with 2 dead cycles between, and expired pulses after each.
5. Pointer wrap: owner 3 (req=1000) releases, then req=0011 -> next grant=0001 (ptr=0). After it releases, with req=0011 -> grant=0010.
6. Reset mid-grant: rstn=0 while grant=0100 -> grant=0000 at the next edge, ptr=0. Then rstn=1 with req=1111 -> grant=0001, not 1000.
